ram_to_avmm_master: RTL and testbench

Avalon-MM write master that copies a block of words from local on-chip RAM to an Avalon-MM slave address range. It is the initiator counterpart of the RAM-facing Avalon-MM slave bridge. It lets FPGA-side logic push captured sample buffers into processor-visible memory or peripheral windows. The block drives a synchronous RAM read port with fixed read latency and absorbs Avalon waitrequest back-pressure with a credit-controlled internal FIFO.

---
 rtl/ram_to_avmm_master.sv | 157 +++++++++++++++
 tb/tb_ram_to_avmm_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_to_avmm_master.sv
// Avalon-MM write master: streams a block of words from a synchronous RAM to an Avalon slave.
// Optional waitrequest timeout enabled by defining RAM_TO_AVMM_TIMEOUT_EN.
module ram_to_avmm_master #(
   parameter int unsigned AW  = 12,
   parameter int unsigned DW  = 32,
   parameter int unsigned PL  = 2,
   parameter int unsigned BAW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AW-1:0]     src_addr,
   input  logic [BAW-1:0]    dst_addr,
   input  logic [AW:0]       len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_rden,
   output logic [AW-1:0]     mem_address,
   input  logic [DW-1:0]     mem_q,
   output logic [BAW-1:0]    avm_address,
   output logic              avm_write,
   output logic [DW-1:0]     avm_writedata,
   output logic [DW/8-1:0]   avm_byteenable,
   input  logic              avm_waitrequest
);
   localparam int unsigned DEPTH = PL + 2;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned BE    = DW / 8;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state;

   logic [AW:0]   len_q, issued, accepted, accepted_nx;
   logic [PL-1:0] vld;
   logic [DW-1:0] fifo [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nx;
   logic [CW-1:0] count, count_nx, after_pop;
   logic [DW-1:0] head_nx;
   logic          push, pop, timeout, done_run, rden_nx;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef RAM_TO_AVMM_TIMEOUT_EN
   logic [7:0] stall_cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             stall_cnt <= '0;
      else if (state != RUN || pop)          stall_cnt <= '0;
      else if (avm_write && avm_waitrequest) stall_cnt <= stall_cnt + 8'd1;
   end
   // Fires on the edge where the stall count reaches 255.
   assign timeout = avm_write && avm_waitrequest && (stall_cnt == 8'd254);
`else
   assign timeout = 1'b0;
`endif

   // Next-cycle FIFO view; issued counts the read in flight this cycle, so
   // issued - accepted is the total credit in use (RAM pipe + FIFO).
   always_comb begin
      push        = vld[PL-1];
      pop         = avm_write && !avm_waitrequest;
      accepted_nx = accepted + (AW+1)'(pop);
      after_pop   = count - CW'(pop);
      count_nx    = after_pop + CW'(push);
      rd_ptr_nx   = pop ? ptr_inc(rd_ptr) : rd_ptr;
      head_nx     = (after_pop == '0) ? mem_q : fifo[rd_ptr_nx];
      done_run    = (accepted_nx == len_q) || timeout;
      rden_nx     = (issued < len_q) && ((issued - accepted_nx) < (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= mem_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         mem_rden       <= 1'b0;
         mem_address    <= '0;
         avm_address    <= '0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
         len_q          <= '0;
         issued         <= '0;
         accepted       <= '0;
         vld            <= '0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
      end else begin
         done           <= 1'b0;
         err            <= 1'b0;
         mem_rden       <= 1'b0;
         avm_write      <= 1'b0;
         avm_byteenable <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q       <= len;
                  issued      <= '0;
                  accepted    <= '0;
                  avm_address <= dst_addr;
                  mem_address <= src_addr;
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state    <= RUN;
                     busy     <= 1'b1;
                     mem_rden <= 1'b1;
                     issued   <= (AW+1)'(1);
                  end
               end
            end
            RUN: begin
               vld      <= PL'({vld, mem_rden});
               count    <= count_nx;
               rd_ptr   <= rd_ptr_nx;
               accepted <= accepted_nx;
               if (push) wr_ptr <= ptr_inc(wr_ptr);
               if (pop)  avm_address <= avm_address + BAW'(BE);
               if (done_run) begin
                  // Normal completion leaves pipe and FIFO empty; timeout discards them.
                  state  <= FIN;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  err    <= timeout;
                  vld    <= '0;
                  count  <= '0;
                  rd_ptr <= '0;
                  wr_ptr <= '0;
               end else begin
                  if (rden_nx) begin
                     mem_rden    <= 1'b1;
                     mem_address <= mem_address + AW'(1);
                     issued      <= issued + (AW+1)'(1);
                  end
                  if (count_nx != '0) begin
                     avm_write      <= 1'b1;
                     avm_byteenable <= '1;
                     avm_writedata  <= head_nx;
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_to_avmm_master.sv
// Bench for ram_to_avmm_master: RAM model, write/read scoreboards and a transfer vector table.
// Runs the timeout scenario as well when RAM_TO_AVMM_TIMEOUT_EN is defined.
module tb_ram_to_avmm_master;
   localparam int PL    = 2;
   localparam int DEPTH = PL + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] src_addr;
   logic [31:0] dst_addr;
   logic [12:0] len;
   logic        busy, done, err, mem_rden, avm_write, avm_waitrequest;
   logic [11:0] mem_address;
   logic [31:0] mem_q, avm_address, avm_writedata;
   logic [3:0]  avm_byteenable;

   ram_to_avmm_master dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .busy(busy), .done(done), .err(err), .mem_rden(mem_rden),
      .mem_address(mem_address), .mem_q(mem_q), .avm_address(avm_address),
      .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] src;
      logic [31:0] dst;
      int          n;
      int          ws;
      int          we;
      int          poke;
      int          exp_done;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int rel = 0;
   int ws = 0;
   int we = -1;
   int outstanding = 0;
   int n_acc = 0;
   logic [11:0] rq[$];
   logic [63:0] wq[$];

   function automatic logic [31:0] ram_word(input logic [11:0] a);
      return {8'hA0, 4'h0, a, 8'h5C};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // RAM model with PL-cycle read latency
   logic [31:0] qpipe [PL];
   always @(posedge clk) begin
      qpipe[0] <= mem_rden ? ram_word(mem_address) : 32'hDEAD_BEEF;
      for (int i = 1; i < PL; i++) qpipe[i] <= qpipe[i-1];
   end
   assign mem_q = qpipe[PL-1];

   // Cycle index within a transfer: 1 is the cycle after start is accepted
   always @(posedge clk) rel <= (start && !busy && !done) ? 1 : rel + 1;

   initial begin
      avm_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         avm_waitrequest = (rel >= ws) && (rel <= we);
      end
   end

   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_data;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold_write", avm_write, 1'b1);
            check("stall_hold_addr", avm_address, prev_addr);
            check("stall_hold_data", avm_writedata, prev_data);
         end
         if (mem_rden) begin
            if (rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rden actual=%0h expected=none", mem_address);
            end else begin
               check("rden_addr", mem_address, rq.pop_front());
            end
            outstanding++;
            check("credit_le_depth", outstanding <= DEPTH, 1'b1);
         end
         if (avm_write) begin
            check("byteenable", avm_byteenable, 4'hF);
            if (!avm_waitrequest) begin
               if (wq.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_write actual=%0h expected=none", avm_address);
               end else begin
                  logic [63:0] e;
                  e = wq.pop_front();
                  check("wr_addr", avm_address, e[63:32]);
                  check("wr_data", avm_writedata, e[31:0]);
               end
               outstanding--;
               n_acc++;
            end
         end
         prev_stall = avm_write && avm_waitrequest;
         prev_addr  = avm_address;
         prev_data  = avm_writedata;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_rden"}, mem_rden, 1'b0);
      check({tag, "_maddr"}, mem_address, 12'h0);
      check({tag, "_write"}, avm_write, 1'b0);
      check({tag, "_aaddr"}, avm_address, 32'h0);
      check({tag, "_wdata"}, avm_writedata, 32'h0);
      check({tag, "_be"}, avm_byteenable, 4'h0);
   endtask

   task automatic run_xfer(input vec_t v, input logic exp_err);
      logic [11:0] a;
      bit seen;
      for (int i = 0; i < v.n; i++) begin
         a = v.src + 12'(i);
         rq.push_back(a);
         wq.push_back({v.dst + 32'(4 * i), ram_word(a)});
      end
      @(negedge clk);
      src_addr = v.src; dst_addr = v.dst; len = 13'(v.n);
      ws = v.ws; we = v.we; start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         @(negedge clk);
         start = (v.poke != 0) && (rel == v.poke);
         if (rel == 1) check("busy_cycle1", busy, v.n > 0);
         if (done) begin
            seen = 1'b1;
            check("done_cycle", 32'(rel), 32'(v.exp_done));
            check("err_at_done", err, exp_err);
            check("busy_at_done", busy, 1'b0);
         end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=none expected=cycle%0d", v.exp_done);
      end
      @(negedge clk);
      start = 1'b0; ws = 0; we = -1;
      check("done_one_cycle", done, 1'b0);
      if (exp_err) begin
         rq.delete(); wq.delete(); outstanding = 0;
      end else begin
         check("wq_drained", 32'(wq.size()), 32'd0);
         check("rq_drained", 32'(rq.size()), 32'd0);
      end
   endtask

   vec_t vecs[7];
   int   base;
   int   c;

   initial begin
      vecs[0] = '{12'h010, 32'h0000_1000,  4, 0, -1, 0,  8};
      vecs[1] = '{12'h010, 32'h0000_1000,  4, 5,  9, 0, 13};
      vecs[2] = '{12'h020, 32'h0000_2000,  0, 0, -1, 0,  1};
      vecs[3] = '{12'hFFE, 32'h0000_3000,  4, 0, -1, 3,  8};
      vecs[4] = '{12'h100, 32'hFFFF_FFF8,  3, 0, -1, 7,  7};
      vecs[5] = '{12'h040, 32'h0000_4000,  8, 5,  9, 0, 17};
      vecs[6] = '{12'h080, 32'h0000_5000, 10, 0, -1, 0, 14};

      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_xfer(vecs[i], 1'b0);

      // Reset after two acceptances of an 8-word transfer
      base = n_acc;
      for (int i = 0; i < 8; i++) begin
         rq.push_back(12'h200 + 12'(i));
         wq.push_back({32'h6000 + 32'(4 * i), ram_word(12'h200 + 12'(i))});
      end
      @(negedge clk);
      src_addr = 12'h200; dst_addr = 32'h6000; len = 13'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (n_acc < base + 2 && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (n_acc < base + 2) begin
         checks++; failures++;
         $display("FAIL mid_reset_wait actual=%0d expected=2", n_acc - base);
      end
      reset = 1'b1;
      #1;
      check_idle_outputs("midreset");
      repeat (2) begin
         @(negedge clk);
         check("no_done_in_reset", done, 1'b0);
      end
      rq.delete(); wq.delete(); outstanding = 0;
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("postreset");
      run_xfer('{12'h300, 32'h0000_7000, 5, 0, -1, 0, 9}, 1'b0);

`ifdef RAM_TO_AVMM_TIMEOUT_EN
      // Slave never accepts: 255 stalled cycles from cycle 4, then done+err
      run_xfer('{12'h010, 32'h0000_8000, 4, 1, 100000, 0, 259}, 1'b1);
      run_xfer(vecs[0], 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
